// File: rtl/bit_unstuff_if.sv
// bit_unstuff_if: bit-stream handshake bundle for the USB bit unstuffer.
// Inputs: bstr_in, bstr_in_ready, in_done. Outputs: bstr_out, bstr_out_ready, out_done, stuff_err.
interface bit_unstuff_if;
    logic bstr_in;
    logic bstr_in_ready;
    logic in_done;
    logic bstr_out;
    logic bstr_out_ready;
    logic out_done;
    logic stuff_err;

    modport master (
        output bstr_in,
        output bstr_in_ready,
        output in_done,
        input  bstr_out,
        input  bstr_out_ready,
        input  out_done,
        input  stuff_err
    );

    modport slave (
        input  bstr_in,
        input  bstr_in_ready,
        input  in_done,
        output bstr_out,
        output bstr_out_ready,
        output out_done,
        output stuff_err
    );
endinterface

// File: rtl/bit_unstuff.sv
// bit_unstuff: removes the stuffed 0 after RUN_LEN ones, flags violations.
// Ports: clk, rst_b (async, active-high), bus (bit_unstuff_if.slave).
// Option BIT_UNSTUFF_ERR_HOLD_EN: error state sticky until in_done.
module bit_unstuff #(
    parameter  int unsigned RUN_LEN = 6,
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    bit_unstuff_if.slave  bus
);

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        STRIP = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             fwd;

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state_q <= DATA;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rdy_d   = 1'b0;
        done_d  = 1'b0;
        fwd     = 1'b0;
`ifdef BIT_UNSTUFF_ERR_HOLD_EN
        err_d   = (state_q == ERR);
`else
        err_d   = 1'b0;
`endif
        if (bus.in_done) begin
            // End of packet wins over any bit in the same cycle.
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = DATA;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                DATA: begin
                    fwd = bus.bstr_in_ready;
                end
                STRIP: begin
                    if (bus.bstr_in_ready) begin
                        cnt_d = '0;
                        if (bus.bstr_in) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                ERR: begin
`ifndef BIT_UNSTUFF_ERR_HOLD_EN
                    // Transient: behaves as DATA this cycle.
                    state_d = DATA;
                    fwd     = bus.bstr_in_ready;
`endif
                end
                default: begin
                    state_d = DATA;
                end
            endcase
            if (fwd) begin
                out_d = bus.bstr_in;
                rdy_d = 1'b1;
                if (bus.bstr_in) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = STRIP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        end
    end

    assign bus.bstr_out       = out_q;
    assign bus.bstr_out_ready = rdy_q;
    assign bus.out_done       = done_q;
    assign bus.stuff_err      = err_q;

endmodule

// File: tb/tb_bit_unstuff.sv
// tb_bit_unstuff: directed table plus randomized checks against a model.
// Drives bit_unstuff through its interface; prints one summary line.
module tb_bit_unstuff;

    localparam int RUN_LEN = 6;

    logic clk;
    logic rst_b;

    bit_unstuff_if bus ();

    bit_unstuff #(.RUN_LEN(RUN_LEN)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic  r;
        logic  b;
        logic  d;
        logic  er;
        logic  eo;
        logic  ee;
        logic  ed;
        string nm;
    } vec_t;

    vec_t tbl[$];

    // Model: window of recently forwarded bits since the last stuff point.
    logic hist[$];
    logic m_hold, m_out, m_rdy, m_done, m_err;

    function automatic bit stuff_due();
        if (hist.size() < RUN_LEN) return 1'b0;
        foreach (hist[i]) if (hist[i] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_hold = 0; m_out = 0; m_rdy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model(input logic r, input logic b, input logic d);
        m_rdy  = 0;
        m_done = 0;
        m_err  = m_hold;
        if (d) begin
            m_done = 1;
            m_hold = 0;
            m_err  = 0;
            hist.delete();
        end else if (m_hold) begin
        end else if (r) begin
            if (stuff_due()) begin
                hist.delete();
                if (b) begin
                    m_err = 1;
`ifdef BIT_UNSTUFF_ERR_HOLD_EN
                    m_hold = 1;
`endif
                end
            end else begin
                hist.push_back(b);
                if (hist.size() > RUN_LEN) void'(hist.pop_front());
                m_out = b;
                m_rdy = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic d);
        bus.bstr_in_ready = r;
        bus.bstr_in       = b;
        bus.in_done       = d;
        model(r, b, d);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, b, d, er, eo, ee, ed,
                                input string nm);
        vec_t v;
        v.r = r; v.b = b; v.d = d;
        v.er = er; v.eo = eo; v.ee = ee; v.ed = ed;
        v.nm = nm;
        tbl.push_back(v);
    endfunction

    function automatic void add_ones(input int n, input string nm);
        for (int i = 0; i < n; i++) add(1, 1, 0, 1, 1, 0, 0, nm);
    endfunction

    task automatic chk_all(input string nm, input logic er, eo, ee, ed);
        chk({nm, " rdy"},  bus.bstr_out_ready, er);
        chk({nm, " out"},  bus.bstr_out,       eo);
        chk({nm, " err"},  bus.stuff_err,      ee);
        chk({nm, " done"}, bus.out_done,       ed);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1;
        bus.bstr_in_ready = 0;
        bus.bstr_in = 0;
        bus.in_done = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_b = 0;
    endtask

    initial begin
        rst_b = 1;
        bus.bstr_in_ready = 0;
        bus.bstr_in = 0;
        bus.in_done = 0;
        model_reset();

        // plain data
        add(1, 1, 0, 1, 1, 0, 0, "plain");
        add(1, 0, 0, 1, 0, 0, 0, "plain");
        add(1, 1, 0, 1, 1, 0, 0, "plain");
        add(1, 1, 0, 1, 1, 0, 0, "plain");
        add(1, 0, 0, 1, 0, 0, 0, "plain");
        add(0, 0, 1, 0, 0, 0, 1, "plain eop");
        // stuffed zero stripped
        add_ones(6, "strip");
        add(1, 0, 0, 0, 1, 0, 0, "strip gap");
        add(1, 1, 0, 1, 1, 0, 0, "strip after");
        add(0, 0, 1, 0, 1, 0, 1, "strip eop");
        // violation
        add_ones(6, "viol");
        add(1, 1, 0, 0, 1, 1, 0, "viol err");
`ifdef BIT_UNSTUFF_ERR_HOLD_EN
        add(1, 0, 0, 0, 1, 1, 0, "viol hold");
        add(0, 0, 0, 0, 1, 1, 0, "viol idle");
        add(0, 0, 1, 0, 1, 0, 1, "viol eop");
`else
        add(1, 0, 0, 1, 0, 0, 0, "viol next");
        add(0, 0, 1, 0, 0, 0, 1, "viol eop");
`endif
        // six ones then end of packet, then a fresh packet
        add_ones(6, "run eop");
        add(0, 0, 1, 0, 1, 0, 1, "run eop done");
        add_ones(6, "pkt2");
        add(1, 0, 0, 0, 1, 0, 0, "pkt2 strip");
        add(0, 0, 1, 0, 1, 0, 1, "pkt2 eop");
        // count persists across idle
        add_ones(5, "idle");
        add(0, 0, 0, 0, 1, 0, 0, "idle gap");
        add(0, 1, 0, 0, 1, 0, 0, "idle gap");
        add(0, 0, 0, 0, 1, 0, 0, "idle gap");
        add(1, 1, 0, 1, 1, 0, 0, "idle sixth");
        add(1, 0, 0, 0, 1, 0, 0, "idle strip");
        add(0, 0, 1, 0, 1, 0, 1, "idle eop");
        // in_done beats a valid bit in the same cycle
        add_ones(5, "prio");
        add(1, 1, 1, 0, 1, 0, 1, "prio done");
        add(1, 1, 0, 1, 1, 0, 0, "prio one");
        add(1, 0, 0, 1, 0, 0, 0, "prio zero");
        add(0, 0, 1, 0, 0, 0, 1, "prio eop");

        do_reset();
        chk_all("reset", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].b, tbl[i].d);
            chk_all(tbl[i].nm, tbl[i].er, tbl[i].eo, tbl[i].ee, tbl[i].ed);
        end

        // async reset in the middle of a run of ones
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        #2;
        rst_b = 1;
        #1;
        chk_all("async rst", 0, 0, 0, 0);
        model_reset();
        bus.bstr_in_ready = 0;
        @(negedge clk);
        rst_b = 0;
        step(1, 1, 0);
        chk_all("post rst a", 1, 1, 0, 0);
        step(1, 1, 0);
        chk_all("post rst b", 1, 1, 0, 0);
        step(1, 0, 0);
        chk_all("post rst c", 1, 0, 0, 0);
        step(0, 0, 0);
        chk_all("post rst idle", 0, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, b, d;
            d = ($urandom_range(39) == 0);
            r = ($urandom_range(3) != 0);
            b = ($urandom_range(99) < 85);
            step(r, b, d);
            chk_all("rand", m_rdy, m_out, m_err, m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
